// File: rtl/axi_outstanding_limiter.sv
// AXI outstanding-burst governor: counts AW->B and AR->R-last in flight
// and withholds AW/AR handshakes while the configured limit is reached.
module axi_outstanding_limiter #(
    parameter int MAX_WR = 8,
    parameter int MAX_RD = 8,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_awvalid,
    output logic          s_awready,
    output logic          m_awvalid,
    input  logic          m_awready,
    input  logic          s_arvalid,
    output logic          s_arready,
    output logic          m_arvalid,
    input  logic          m_arready,
    input  logic          bvalid,
    input  logic          bready,
    input  logic          rvalid,
    input  logic          rready,
    input  logic          rlast,
    output logic [CW-1:0] wr_cnt,
    output logic [CW-1:0] rd_cnt,
    output logic          wr_full,
    output logic          rd_full,
    output logic          err_underflow
);

    logic [CW-1:0] r_wr_cnt;
    logic [CW-1:0] r_rd_cnt;
    logic          r_err;

    logic [CW-1:0] w_wr_nxt;
    logic [CW-1:0] w_rd_nxt;
    logic          w_wr_unf;
    logic          w_rd_unf;
    logic          w_wr_full;
    logic          w_rd_full;
    logic          w_aw_fire;
    logic          w_b_fire;
    logic          w_ar_fire;
    logic          w_rl_fire;

    // Full flags come from registered counts only, so a returning B/R
    // cannot reopen AW/AR within the same cycle.
    assign w_wr_full = (r_wr_cnt == CW'(MAX_WR));
    assign w_rd_full = (r_rd_cnt == CW'(MAX_RD));

    assign m_awvalid = s_awvalid & ~w_wr_full;
    assign s_awready = m_awready & ~w_wr_full;
    assign m_arvalid = s_arvalid & ~w_rd_full;
    assign s_arready = m_arready & ~w_rd_full;

    assign w_aw_fire = m_awvalid & m_awready;
    assign w_b_fire  = bvalid & bready;
    assign w_ar_fire = m_arvalid & m_arready;
    assign w_rl_fire = rvalid & rready & rlast;

    // Next write count; a response with nothing in flight saturates at 0.
    always_comb begin
        w_wr_nxt = r_wr_cnt;
        w_wr_unf = 1'b0;
        if (w_aw_fire && !w_b_fire) begin
            w_wr_nxt = r_wr_cnt + CW'(1);
        end else if (!w_aw_fire && w_b_fire) begin
            if (r_wr_cnt == '0) begin
                w_wr_unf = 1'b1;
            end else begin
                w_wr_nxt = r_wr_cnt - CW'(1);
            end
        end
    end

    // Next read count; only the last R beat retires a burst.
    always_comb begin
        w_rd_nxt = r_rd_cnt;
        w_rd_unf = 1'b0;
        if (w_ar_fire && !w_rl_fire) begin
            w_rd_nxt = r_rd_cnt + CW'(1);
        end else if (!w_ar_fire && w_rl_fire) begin
            if (r_rd_cnt == '0) begin
                w_rd_unf = 1'b1;
            end else begin
                w_rd_nxt = r_rd_cnt - CW'(1);
            end
        end
    end

    // Count and sticky-error registers; error clears only on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_wr_cnt <= w_wr_nxt;
            r_rd_cnt <= w_rd_nxt;
            r_err    <= r_err | w_wr_unf | w_rd_unf;
        end
    end

    assign wr_cnt        = r_wr_cnt;
    assign rd_cnt        = r_rd_cnt;
    assign wr_full       = w_wr_full;
    assign rd_full       = w_rd_full;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// Bench for axi_outstanding_limiter (MAX_WR=2, MAX_RD=4): vector table
// through a scoreboard queue, plus async-reset and read-underflow sequences.
module tb_axi_outstanding_limiter;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_awvalid = 0, m_awready = 0;
    logic          s_arvalid = 0, m_arready = 0;
    logic          bvalid = 0, bready = 0;
    logic          rvalid = 0, rready = 0, rlast = 0;
    logic          s_awready, m_awvalid, s_arready, m_arvalid;
    logic [CW-1:0] wr_cnt, rd_cnt;
    logic          wr_full, rd_full, err_underflow;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi_outstanding_limiter #(.MAX_WR(2), .MAX_RD(4), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .bvalid(bvalid), .bready(bready),
        .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt),
        .wr_full(wr_full), .rd_full(rd_full),
        .err_underflow(err_underflow)
    );

    typedef struct {
        logic aw, awr, ar, arr, bv, br, rv, rr, rl;
        logic e_mav, e_sar, e_mar, e_sarr;
        int   e_wc, e_rc;
        logic e_wf, e_rf, e_err;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(
        input logic aw, awr, ar, arr, bv, br, rv, rr, rl,
        input logic mav, sar, mar, sarr,
        input int wc, rc, input logic wf, rf, er);
        vec_t v;
        v.aw = aw; v.awr = awr; v.ar = ar; v.arr = arr;
        v.bv = bv; v.br = br; v.rv = rv; v.rr = rr; v.rl = rl;
        v.e_mav = mav; v.e_sar = sar; v.e_mar = mar; v.e_sarr = sarr;
        v.e_wc = wc; v.e_rc = rc; v.e_wf = wf; v.e_rf = rf; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int wc, input int rc,
                             input logic wf, input logic rf, input logic er);
        chk({tag, " wr_cnt"}, int'(wr_cnt), wc);
        chk({tag, " rd_cnt"}, int'(rd_cnt), rc);
        chk({tag, " wr_full"}, int'(wr_full), int'(wf));
        chk({tag, " rd_full"}, int'(rd_full), int'(rf));
        chk({tag, " err"}, int'(err_underflow), int'(er));
    endtask

    task automatic drive(input vec_t v);
        s_awvalid = v.aw; m_awready = v.awr;
        s_arvalid = v.ar; m_arready = v.arr;
        bvalid = v.bv; bready = v.br;
        rvalid = v.rv; rready = v.rr; rlast = v.rl;
    endtask

    task automatic idle();
        s_awvalid = 0; m_awready = 0; s_arvalid = 0; m_arready = 0;
        bvalid = 0; bready = 0; rvalid = 0; rready = 0; rlast = 0;
    endtask

    initial begin
        vec_t v;
        string tag;
        //           aw awr ar arr bv br rv rr rl  mav sar mar sarr wc rc wf rf er
        tbl.push_back(mk(1,1,0,0,0,0,0,0,0, 1,1,0,0, 1,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,0, 1,1,0,0, 2,0,1,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,0, 0,0,0,0, 2,0,1,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,0, 0,0,0,0, 2,0,1,0,0));
        tbl.push_back(mk(1,1,0,0,1,1,0,0,0, 0,0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,0,0,0,0, 1,1,0,0, 2,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1,1,0,0,0, 0,0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,1,1,0,0,0, 1,1,0,0, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,0,0,0, 0,0,0,0, 1,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,1,0,0,0, 0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,0,0,0,0,0, 0,0,1,1, 0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,1,0, 0,0,0,0, 0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,1,0, 0,0,0,0, 0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,1,0, 0,0,0,0, 0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,0,1, 0,0,0,0, 0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,1,1, 0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,0, 0,0,1,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,1,0,0,0, 0,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(1,1,1,1,0,0,0,0,0, 1,1,1,1, 1,1,0,0,1));
        tbl.push_back(mk(1,1,1,1,0,0,0,0,0, 1,1,1,1, 2,2,1,0,1));
        tbl.push_back(mk(0,0,1,1,0,0,0,0,0, 0,0,1,1, 2,3,1,0,1));
        tbl.push_back(mk(0,0,1,1,0,0,0,0,0, 0,0,1,1, 2,4,1,1,1));
        tbl.push_back(mk(0,0,1,1,0,0,0,0,0, 0,0,0,0, 2,4,1,1,1));
        tbl.push_back(mk(0,0,1,1,0,0,1,1,1, 0,0,0,0, 2,3,1,0,1));

        // reset state
        idle();
        repeat (2) @(posedge clk);
        #1 chk_state("reset", 0, 0, 0, 0, 0);
        @(negedge clk) rst = 0;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            #1;
            tag = $sformatf("v%0d", i);
            chk({tag, " m_awvalid"}, int'(m_awvalid), int'(sb[0].e_mav));
            chk({tag, " s_awready"}, int'(s_awready), int'(sb[0].e_sar));
            chk({tag, " m_arvalid"}, int'(m_arvalid), int'(sb[0].e_mar));
            chk({tag, " s_arready"}, int'(s_arready), int'(sb[0].e_sarr));
            @(posedge clk);
            #1;
            v = sb.pop_front();
            chk_state(tag, v.e_wc, v.e_rc, v.e_wf, v.e_rf, v.e_err);
        end

        // asynchronous reset mid-cycle with wr_cnt=2, rd_cnt=3
        @(negedge clk);
        idle();
        #2 rst = 1;
        #1 chk_state("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk) rst = 0;
        @(posedge clk);
        #1 chk_state("post_rst", 0, 0, 0, 0, 0);

        // read-side underflow: R last with nothing outstanding
        @(negedge clk);
        rvalid = 1; rready = 1; rlast = 1;
        @(posedge clk);
        #1 chk_state("rd_unf", 0, 0, 0, 0, 1);
        @(negedge clk) idle();
        repeat (2) @(posedge clk);
        #1 chk_state("rd_unf_hold", 0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
